// File: rtl/ppu_pool_sequencer_if.sv
// ppu_pool_sequencer_if
// Bundles the three sides of the pooling sequencer into one interface:
//   - the element input stream (valid/ready plus the data)
//   - the pooled-result output stream (valid/ready plus the data)
//   - the control/feedback pins of the PPU running-max comparator
// The sequencer connects through the 'slave' modport.
// The surrounding logic (PPU stream, writeback, comparator) connects through 'master'.
interface ppu_pool_sequencer_if;

    // Element input stream
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    // Synchronous abort of a partial window
    logic       clear;

    // Quantisation zero point (only used when ReLU fusion is built in)
    logic [7:0] zero_point;

    // Comparator drive and feedback
    logic       cmp_init;
    logic       cmp_en;
    logic [7:0] cmp_data_in;
    logic [7:0] cmp_data_out;

    // Pooled-result output stream
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    // Sequencer side
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  clear,
        input  zero_point,
        output cmp_init,
        output cmp_en,
        output cmp_data_in,
        input  cmp_data_out,
        output out_valid,
        input  out_ready,
        output out_data
    );

    // Environment side: stream source, result sink, comparator
    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output clear,
        output zero_point,
        input  cmp_init,
        input  cmp_en,
        input  cmp_data_in,
        output cmp_data_out,
        input  out_valid,
        output out_ready,
        input  out_data
    );

endinterface

// File: rtl/ppu_pool_sequencer.sv
// ppu_pool_sequencer
//
// Sequences the PPU 8-bit running-max comparator to perform max pooling.
// It takes WIN_SIZE unsigned elements per window and drives the comparator's
// init/en/data_in pins. On the last element of each window it captures the
// comparator's combinational max and holds it on a valid/ready output.
//
// Optional build macro:
//   PPU_POOL_RELU_EN - the captured value becomes max(cmp_data_out, zero_point).
//                      This fuses a ReLU into the pooling step.
//                      When the macro is absent, zero_point is ignored.
module ppu_pool_sequencer #(
    parameter int WIN_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ppu_pool_sequencer_if.slave  bus
);

    // The counter needs at least one bit, even for degenerate parameter values.
    localparam int CNT_W = (WIN_SIZE > 1) ? $clog2(WIN_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  elem_cnt_reg;
    logic [CNT_W-1:0]  elem_cnt_next;
    logic [7:0]        out_data_reg;
    logic [7:0]        capture_value;
    logic              capture;
    logic              in_ready_int;
    logic              acc;
    logic              last_elem;

    // Handshake and comparator drive.
    // in_ready is gated by rst, so it reads 0 while reset is held.
    // All comparator controls derive from acc, so they also drop during reset.
    // The comparator always updates while init is low. Feeding it 0 on idle
    // cycles therefore leaves its stored max unchanged.
    always_comb begin
        in_ready_int = !rst && (state_reg != ST_HOLD) && !bus.clear;
        acc          = bus.in_valid && in_ready_int;
        last_elem    = (elem_cnt_reg == LAST_IDX);
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.cmp_en      = acc;
    assign bus.cmp_init    = acc && (elem_cnt_reg == '0);
    assign bus.cmp_data_in = acc ? bus.in_data : 8'h00;
    assign bus.out_valid   = (state_reg == ST_HOLD);
    assign bus.out_data    = out_data_reg;

    // Select the value latched as the pooled result.
    // cmp_data_out already includes the element being accepted this cycle.
`ifdef PPU_POOL_RELU_EN
    always_comb begin
        capture_value = (bus.cmp_data_out > bus.zero_point) ? bus.cmp_data_out
                                                            : bus.zero_point;
    end
`else
    always_comb begin
        capture_value = bus.cmp_data_out;
    end
`endif

    // Next-state logic: window progress, clear handling, result release.
    always_comb begin
        state_next    = state_reg;
        elem_cnt_next = elem_cnt_reg;
        capture       = 1'b0;
        unique case (state_reg)
            ST_IDLE, ST_ACCUM: begin
                if (bus.clear) begin
                    // Abort any partial window. The next element restarts at init.
                    state_next    = ST_IDLE;
                    elem_cnt_next = '0;
                end else if (acc) begin
                    if (last_elem) begin
                        state_next    = ST_HOLD;
                        elem_cnt_next = '0;
                        capture       = 1'b1;
                    end else begin
                        state_next    = ST_ACCUM;
                        elem_cnt_next = elem_cnt_reg + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // A held result is never dropped by clear; only the handshake
                // releases it.
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                elem_cnt_next = '0;
            end
        endcase
    end

    // State and element counter registers. Asynchronous reset drops any
    // partial window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            elem_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            elem_cnt_reg <= elem_cnt_next;
        end
    end

    // Result register. It changes only on a capture, so it stays stable under
    // back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_reg <= 8'h00;
        end else if (capture) begin
            out_data_reg <= capture_value;
        end
    end

endmodule

// File: tb/tb_ppu_pool_sequencer.sv
// tb_ppu_pool_sequencer
// Directed bench for ppu_pool_sequencer with WIN_SIZE = 4. The bench contains
// a behavioural model of the PPU running-max comparator.
module tb_ppu_pool_sequencer;

    logic clk;
    logic rst;

    ppu_pool_sequencer_if bus();

    ppu_pool_sequencer #(.WIN_SIZE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model: data_out = init ? data_in : max(data_in, stored).
    // The stored value follows data_out every cycle.
    logic [7:0] cmp_store;
    assign bus.cmp_data_out = bus.cmp_init ? bus.cmp_data_in :
                              ((bus.cmp_data_in > cmp_store) ? bus.cmp_data_in : cmp_store);
    always @(posedge clk) cmp_store <= bus.cmp_data_out;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one element at the falling edge and wait (bounded) for in_ready.
    // Check the comparator drive, then let the rising edge take the element.
    task automatic send(input logic [7:0] v, input logic exp_init, input string tag);
        int waited;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        #1;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 50) check({tag, "_ready_timeout"}, 1, 0);
        check({tag, "_init"}, bus.cmp_init, exp_init);
        check({tag, "_data_in"}, bus.cmp_data_in, v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        $display("send %s: elem %0d accepted", tag, v);
    endtask

    // Call at posedge+1 right after the final accept: the result must be valid
    // already, one cycle after the last element.
    task automatic expect_result(input logic [7:0] exp, input string tag);
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_data"}, bus.out_data, exp);
        check({tag, "_busy"}, bus.in_ready, 0);
        $display("result %s: out_data %0d (expect %0d)", tag, bus.out_data, exp);
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.clear      = 1'b0;
        bus.zero_point = 8'h00;
        bus.out_ready  = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_cmp_init", bus.cmp_init, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // Basic back-to-back window
        send(8'd12,  1'b1, "b0");
        send(8'd200, 1'b0, "b1");
        send(8'd7,   1'b0, "b2");
        send(8'd199, 1'b0, "b3");
        expect_result(8'd200, "basic");
        @(posedge clk); #1;
        check("basic_release", bus.out_valid, 0);

        // Gapped window: the comparator must see 0 with en low between elements
        send(8'd12, 1'b1, "g0");
        for (int k = 1; k < 4; k++) begin
            repeat (3) begin
                @(negedge clk); #1;
                check("gap_data_in", bus.cmp_data_in, 0);
                check("gap_en", bus.cmp_en, 0);
            end
            case (k)
                1: send(8'd200, 1'b0, "g1");
                2: send(8'd7,   1'b0, "g2");
                default: send(8'd199, 1'b0, "g3");
            endcase
        end
        expect_result(8'd200, "gapped");
        @(posedge clk); #1;

        // Back-pressure: hold the first result for 5 cycles.
        // A clear pulse during the hold must not drop the result.
        bus.out_ready = 1'b0;
        send(8'd1, 1'b1, "p0");
        send(8'd2, 1'b0, "p1");
        send(8'd3, 1'b0, "p2");
        send(8'd4, 1'b0, "p3");
        expect_result(8'd4, "bp_first");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd9;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.clear = (c == 2);
            #1;
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_data", bus.out_data, 4);
            check("bp_hold_ready", bus.in_ready, 0);
            check("bp_hold_en", bus.cmp_en, 0);
        end
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", bus.out_valid, 0);
        send(8'd9, 1'b1, "q0");
        send(8'd8, 1'b0, "q1");
        send(8'd7, 1'b0, "q2");
        send(8'd6, 1'b0, "q3");
        expect_result(8'd9, "bp_second");
        @(posedge clk); #1;

        // Clear mid-window: 250 must not leak into the following window
        send(8'd250, 1'b1, "c0");
        send(8'd3,   1'b0, "c1");
        @(negedge clk);
        bus.clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 8'd77;
        #1;
        check("clear_ready", bus.in_ready, 0);
        check("clear_en", bus.cmp_en, 0);
        @(posedge clk); #1;
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        check("clear_no_out", bus.out_valid, 0);
        send(8'd5, 1'b1, "c2");
        send(8'd6, 1'b0, "c3");
        send(8'd7, 1'b0, "c4");
        send(8'd8, 1'b0, "c5");
        expect_result(8'd8, "clear");
        @(posedge clk); #1;

        // Asynchronous reset after two elements
        send(8'd50, 1'b1, "r0");
        send(8'd60, 1'b0, "r1");
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd99;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_data", bus.out_data, 0);
        check("arst_in_ready", bus.in_ready, 0);
        check("arst_cmp_en", bus.cmp_en, 0);
        check("arst_cmp_data_in", bus.cmp_data_in, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(8'd10, 1'b1, "a0");
        send(8'd20, 1'b0, "a1");
        send(8'd30, 1'b0, "a2");
        send(8'd40, 1'b0, "a3");
        expect_result(8'd40, "after_rst");
        @(posedge clk); #1;

        // Zero-point / ReLU fusion
        bus.zero_point = 8'd128;
        send(8'd5,   1'b1, "z0");
        send(8'd100, 1'b0, "z1");
        send(8'd127, 1'b0, "z2");
        send(8'd0,   1'b0, "z3");
`ifdef PPU_POOL_RELU_EN
        expect_result(8'd128, "relu_low");
`else
        expect_result(8'd127, "relu_low");
`endif
        @(posedge clk); #1;
        send(8'd5,   1'b1, "z4");
        send(8'd200, 1'b0, "z5");
        send(8'd9,   1'b0, "z6");
        send(8'd1,   1'b0, "z7");
        expect_result(8'd200, "relu_high");
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ppu_pool_sequencer.md
# ppu_pool_sequencer

Drives the PPU's 8-bit running-max comparator so it performs max pooling. Takes an unsigned Qint8 element stream, one pooling window (WIN_SIZE elements) at a time, and generates the comparator's `init`/`en`/`data_in` controls. Captures the comparator's combinational max on each window's final element and presents the pooled value on a valid/ready output. It sits between the PPU input stream and the PPU writeback path, with the comparator instantiated beside it.

## Interface
- `WIN_SIZE`, 4: elements per pooling window (2x2 = 4, 3x3 = 9); legal range 2..16.
- `clk` input 1: clock.
- `rst` input 1: asynchronous reset, active-high.
- `clear` input 1: synchronous abort of the partial window; highest priority after `rst`.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: sequencer accepts `in_data` this cycle.
- `in_data` input 8: unsigned Qint8 element.
- `zero_point` input 8: Qint8 zero point; used only under `PPU_POOL_RELU_EN`.
- `cmp_init` output 1: to comparator `init`.
- `cmp_en` output 1: to comparator `en`; high on every accepted element.
- `cmp_data_in` output 8: to comparator `data_in`.
- `cmp_data_out` input 8: from comparator `data_out`, which is max(`data_in`, stored).
- `out_valid` output 1: pooled result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output 8: pooled result.

## Operation
- Element accept: `acc = in_valid & in_ready`, with `in_ready = !out_valid & !clear`.
- `elem_cnt` has width $clog2(WIN_SIZE). It is 0 at a window start, increments on each `acc`, and returns to 0 after element WIN_SIZE-1.
- Comparator drive, combinational:
  - `cmp_data_in = acc ? in_data : 8'h00`.
  - `cmp_init = acc & (elem_cnt == 0)`.
  - `cmp_en = acc`.
  - 8'h00 during idle cycles keeps the comparator's stored max unchanged, because the comparator always updates when `init` is low.
- States:
  - IDLE: no partial window. `acc` → ACCUM (or → HOLD if WIN_SIZE would be 1; illegal).
  - ACCUM: partial window held. `acc` with `elem_cnt == WIN_SIZE-1` → HOLD. `clear` → IDLE.
  - HOLD: `out_valid = 1`. `out_ready` → IDLE. `clear` does not drop a held result.
- Capture: on the final `acc`, `out_data <= cmp_data_out`, which already includes the final element.
- `clear` in IDLE or ACCUM: `elem_cnt <= 0`, state → IDLE, nothing emitted. The next element asserts `cmp_init`.
- `clear` and `acc` in the same cycle cannot occur, because `in_ready` is low while `clear` is high.
- `out_data` holds its value until the next capture. It is valid only while `out_valid` is high.

## Timing
- Reset values: `out_valid = 0`, `out_data = 8'h00`, `in_ready = 0` while `rst` is high (then 1), `cmp_init = 0`, `cmp_en = 0`, `cmp_data_in = 8'h00`, `elem_cnt = 0`, state IDLE.
- Latency: last element accepted in cycle N → `out_valid` high in cycle N+1.
- Throughput: WIN_SIZE elements plus one bubble cycle per window; the bubble is HOLD with `in_ready = 0`.
- Output back-pressure: while `out_valid & !out_ready`, `out_data` is stable and `in_ready = 0`.
- Input gaps inside a window are allowed; the comparator state is preserved.
- Reset mid-window: partial window discarded, outputs return to reset values in the same cycle, asynchronously.

## Configuration
- `PPU_POOL_RELU_EN` defined: the capture value is max(`cmp_data_out`, `zero_point`), unsigned. This fuses ReLU into pooling.
- `PPU_POOL_RELU_EN` undefined: the capture value is `cmp_data_out`; the `zero_point` port is present but ignored.

## Test plan
- Basic window: WIN_SIZE=4, back-to-back inputs 12, 200, 7, 199, `out_ready = 1` → `cmp_init` high only on the first element; `out_data = 200` one cycle after the 4th accept.
- Gapped input: same values with 3 idle cycles between each → `out_data = 200`; `cmp_data_in = 0` during gaps.
- Back-pressure: two windows {1,2,3,4}, {9,8,7,6}, `out_ready` low for 5 cycles on the first result → `out_data` holds 4 and `in_ready` stays 0 until the handshake; then second result = 9.
- Clear: accept 250, 3, then pulse `clear`, then 5, 6, 7, 8 → a single result of 8; 250 must not leak into it.
- Async reset mid-window, after 2 elements → all outputs at reset values immediately; a following window {10,20,30,40} yields 40.
- With `PPU_POOL_RELU_EN`, `zero_point = 128`, window {5,100,127,0} → 128; window {5,200,9,1} → 200. Without the macro, window {5,100,127,0} → 127.
